// File: rtl/fetch_sequencer_pkg.sv
// Shared definitions for the fetch sequencer: FSM state encodings,
// the PC increment and the default reset/exception vectors.
package fetch_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_STALL = 2'd2,
    ST_FLUSH = 2'd3
  } fetch_state_t;

  localparam logic [31:0] PC_INC           = 32'd4;
  localparam logic [31:0] DEF_RESET_VECTOR = 32'h0000_0000;
  localparam logic [31:0] DEF_EXC_VECTOR   = 32'h0000_0080;

endpackage

// File: rtl/fetch_sequencer.sv
// Fetch sequencer: owns the PC, advances it by 4, holds on decode stall,
// and redirects from EX followed by FLUSH_BUBBLES invalid fetch cycles.
// Optional macro FETCH_ALIGN_CHECK_EN: misaligned redirect targets are sent
// to EXC_VECTOR with a one-cycle MisalignErr pulse. Without it the low two
// target bits are cleared and MisalignErr stays 0.
module fetch_sequencer
  import fetch_sequencer_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR  = DEF_RESET_VECTOR,
  parameter logic [31:0] EXC_VECTOR    = DEF_EXC_VECTOR,
  parameter int          FLUSH_BUBBLES = 1
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Stall,
  input  logic        Redirect,
  input  logic [31:0] RedirectTarget,
  output logic [31:0] Address,
  output logic        FetchValid,
  output logic        Flush,
  output logic [31:0] FetchCount,
  output logic        MisalignErr
);

  // Counter is loaded with bubbles-1 and exits FLUSH on the edge it reads 0.
  localparam logic [1:0] BUB_LOAD = 2'(FLUSH_BUBBLES - 1);

  fetch_state_t r_state, w_state_n;
  logic [31:0]  r_addr, w_addr_n;
  logic [31:0]  r_cnt, w_cnt_n;
  logic [1:0]   r_bub, w_bub_n;
  logic         r_fv, w_fv_n;
  logic         r_flush, w_flush_n;
  logic         r_mis, w_mis_n;
  logic         w_take_redirect;
  logic         w_misalign;
  logic [31:0]  w_tgt;

`ifdef FETCH_ALIGN_CHECK_EN
  assign w_misalign = |RedirectTarget[1:0];
  assign w_tgt      = w_misalign ? EXC_VECTOR : RedirectTarget;
`else
  logic w_unused_align;
  assign w_unused_align = ^{RedirectTarget[1:0], EXC_VECTOR};
  assign w_misalign     = 1'b0;
  assign w_tgt          = {RedirectTarget[31:2], 2'b00};
`endif

  // Next-state and next-output logic; Redirect beats Stall in every live state.
  always_comb begin
    w_state_n       = r_state;
    w_addr_n        = r_addr;
    w_cnt_n         = r_cnt;
    w_bub_n         = r_bub;
    w_fv_n          = r_fv;
    w_flush_n       = r_flush;
    w_mis_n         = 1'b0;
    w_take_redirect = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        w_state_n = ST_RUN;
        w_fv_n    = 1'b1;
        w_flush_n = 1'b0;
      end
      ST_RUN: begin
        if (Redirect) begin
          w_take_redirect = 1'b1;
        end else if (Stall) begin
          w_state_n = ST_STALL;
        end else begin
          w_addr_n = r_addr + PC_INC;
          w_cnt_n  = r_cnt + 32'd1;
        end
      end
      ST_STALL: begin
        if (Redirect) begin
          w_take_redirect = 1'b1;
        end else if (!Stall) begin
          w_addr_n  = r_addr + PC_INC;
          w_cnt_n   = r_cnt + 32'd1;
          w_state_n = ST_RUN;
        end
      end
      ST_FLUSH: begin
        if (Redirect) begin
          w_take_redirect = 1'b1;
        end else if (r_bub == 2'd0) begin
          w_state_n = ST_RUN;
          w_fv_n    = 1'b1;
          w_flush_n = 1'b0;
        end else begin
          w_bub_n = r_bub - 2'd1;
        end
      end
    endcase
    if (w_take_redirect) begin
      w_addr_n  = w_tgt;
      w_fv_n    = 1'b0;
      w_flush_n = 1'b1;
      w_bub_n   = BUB_LOAD;
      w_state_n = ST_FLUSH;
      w_mis_n   = w_misalign;
    end
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      r_state <= ST_IDLE;
      r_addr  <= RESET_VECTOR;
      r_cnt   <= 32'd0;
      r_bub   <= 2'd0;
      r_fv    <= 1'b0;
      r_flush <= 1'b0;
      r_mis   <= 1'b0;
    end else begin
      r_state <= w_state_n;
      r_addr  <= w_addr_n;
      r_cnt   <= w_cnt_n;
      r_bub   <= w_bub_n;
      r_fv    <= w_fv_n;
      r_flush <= w_flush_n;
      r_mis   <= w_mis_n;
    end
  end

  assign Address     = r_addr;
  assign FetchValid  = r_fv;
  assign Flush       = r_flush;
  assign FetchCount  = r_cnt;
  assign MisalignErr = r_mis;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Scoreboard bench for fetch_sequencer: a driver applies directed and random
// stimulus, steps a behavioural model and queues the expected outputs; a
// monitor pops and compares after every rising edge.
module tb_fetch_sequencer;

  localparam int          FB  = 2;
  localparam logic [31:0] RV  = 32'h0000_0000;
  localparam logic [31:0] EXV = 32'h0000_0080;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall;
  logic        redir;
  logic [31:0] tgt;
  logic [31:0] addr;
  logic        fv;
  logic        flush;
  logic [31:0] fcnt;
  logic        mis;

  fetch_sequencer #(
    .RESET_VECTOR (RV),
    .EXC_VECTOR   (EXV),
    .FLUSH_BUBBLES(FB)
  ) dut (
    .Clk           (clk),
    .Reset         (rst_n),
    .Stall         (stall),
    .Redirect      (redir),
    .RedirectTarget(tgt),
    .Address       (addr),
    .FetchValid    (fv),
    .Flush         (flush),
    .FetchCount    (fcnt),
    .MisalignErr   (mis)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic        fv;
    logic        flush;
    logic [31:0] cnt;
    logic        mis;
    string       tag;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  // Behavioural model: the machine is "started" once out of reset and
  // "bubbles" counts the invalid fetch cycles still owed after a redirect.
  logic [31:0] m_pc;
  logic [31:0] m_cnt;
  logic        m_fv, m_fl, m_mis, m_started;
  int          m_bubbles;

  function automatic void model_step(input logic r, input logic s,
                                     input logic d, input logic [31:0] t);
    if (!r) begin
      m_pc = RV; m_cnt = 0; m_fv = 0; m_fl = 0; m_mis = 0;
      m_started = 0; m_bubbles = 0;
    end else if (!m_started) begin
      m_started = 1; m_fv = 1; m_fl = 0; m_mis = 0;
    end else begin
      m_mis = 0;
      if (d) begin
`ifdef FETCH_ALIGN_CHECK_EN
        if (t % 4 != 0) begin m_pc = EXV; m_mis = 1; end
        else m_pc = t;
`else
        m_pc = t - (t % 4);
`endif
        m_bubbles = FB; m_fv = 0; m_fl = 1;
      end else if (m_bubbles > 0) begin
        m_bubbles = m_bubbles - 1;
        if (m_bubbles == 0) begin m_fv = 1; m_fl = 0; end
      end else if (!s) begin
        m_pc  = m_pc + 4;
        m_cnt = m_cnt + 1;
      end
    end
  endfunction

  // Apply one cycle of inputs, predict the post-edge outputs, queue them.
  task automatic cyc(input logic r, input logic s, input logic d,
                     input logic [31:0] t, input string tag);
    exp_t e;
    @(negedge clk);
    rst_n = r; stall = s; redir = d; tgt = t;
    model_step(r, s, d, t);
    e.addr = m_pc; e.fv = m_fv; e.flush = m_fl; e.cnt = m_cnt;
    e.mis = m_mis; e.tag = tag;
    exp_q.push_back(e);
  endtask

  // Monitor: every edge produces an output word; compare it to the head.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n_checks++;
        if (addr !== e.addr || fv !== e.fv || flush !== e.flush ||
            fcnt !== e.cnt || mis !== e.mis) begin
          n_errors++;
          $display("FAIL %s: got addr=%h fv=%b flush=%b cnt=%0d mis=%b, want addr=%h fv=%b flush=%b cnt=%0d mis=%b",
                   e.tag, addr, fv, flush, fcnt, mis,
                   e.addr, e.fv, e.flush, e.cnt, e.mis);
        end
      end
    end
  end

  initial begin
    rst_n = 1'b0; stall = 1'b0; redir = 1'b0; tgt = 32'h0;
    // Reset, then sequential advance 0,4,8,C.
    cyc(0, 0, 0, 0, "reset0");
    cyc(0, 1, 1, 32'h40, "reset1_inputs_ignored");
    cyc(1, 1, 1, 32'h80, "idle_to_run");
    cyc(1, 0, 0, 0, "adv4");
    cyc(1, 0, 0, 0, "adv8");
    // Stall at 8 for 3 cycles, then release.
    cyc(1, 1, 0, 0, "stall1");
    cyc(1, 1, 0, 0, "stall2");
    cyc(1, 1, 0, 0, "stall3");
    cyc(1, 0, 0, 0, "stall_release");
    cyc(1, 0, 0, 0, "adv10");
    // Redirect to 0x40 from 0x10 with two bubbles.
    cyc(1, 0, 1, 32'h40, "redir40");
    cyc(1, 0, 0, 0, "bubble2");
    cyc(1, 0, 0, 0, "target_valid");
    cyc(1, 0, 0, 0, "adv44");
    // Redirect with stall, then re-redirect during FLUSH with stall held.
    cyc(1, 1, 1, 32'h100, "redir100_stall");
    cyc(1, 1, 1, 32'h200, "reredir200");
    cyc(1, 1, 0, 0, "flush_stall_ignored");
    cyc(1, 1, 0, 0, "flush_exit_stall");
    cyc(1, 0, 0, 0, "adv204");
    // Wrap across 2^32.
    cyc(1, 0, 1, 32'hFFFF_FFF8, "redir_wrap");
    cyc(1, 0, 0, 0, "wrap_b");
    cyc(1, 0, 0, 0, "wrap_valid");
    cyc(1, 0, 0, 0, "wrap_fffc");
    cyc(1, 0, 0, 0, "wrap_zero");
    // Misaligned redirect.
    cyc(1, 0, 1, 32'h42, "redir42");
    cyc(1, 0, 0, 0, "mis_drop");
    cyc(1, 0, 0, 0, "mis_valid");
    // Reset in the middle of FLUSH.
    cyc(1, 0, 1, 32'h300, "redir300");
    cyc(0, 0, 0, 0, "reset_mid_flush");
    cyc(1, 0, 0, 0, "restart");
    cyc(1, 0, 0, 0, "restart_adv");
    // Random traffic, with occasional reset.
    for (int i = 0; i < 3000; i++) begin
      logic        r, s, d;
      logic [31:0] t;
      r = ($urandom_range(0, 199) != 0);
      s = ($urandom_range(0, 3) == 0);
      d = ($urandom_range(0, 9) == 0);
      t = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                      : $urandom;
      cyc(r, s, d, t, "random");
    end
    @(posedge clk);
    #2;
    n_checks++;
    if (exp_q.size() != 0) begin
      n_errors++;
      $display("FAIL drain: %0d expected outputs left, want 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
